// File: rtl/pic85_pkg.sv
// Shared constants for the pic85 interrupt controller: bus opcodes,
// port offsets, command bits and acknowledge-sequence state encoding.
package pic85_pkg;

  localparam logic [7:0] OP_CALL = 8'hCD;

  localparam logic [1:0] PORT_CMD = 2'd0;
  localparam logic [1:0] PORT_IMR = 2'd1;
  localparam logic [1:0] PORT_IRR = 2'd2;

  localparam int unsigned CMD_NSEOI = 5;
  localparam int unsigned CMD_SEOI  = 6;

  localparam logic [1:0] ACK_IDLE = 2'd0;
  localparam logic [1:0] ACK1     = 2'd1;
  localparam logic [1:0] ACK2     = 2'd2;
  localparam logic [1:0] ACK3     = 2'd3;

endpackage

// File: rtl/pic85_prio.sv
// Combinational priority encoder: reports the lowest set index of vec.
module pic85_prio #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] vec,
  output logic [2:0]   idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !valid) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic85.sv
// Fixed-priority interrupt controller for core85: latches request edges,
// raises intr, and answers INTA cycles with CALL <vector>.
module pic85 import pic85_pkg::*; #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [7:0]  IO_BASE  = 8'h20,
  parameter logic [15:0] VEC_BASE = 16'h1000,
  parameter int unsigned VEC_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [7:0]         ioaddr,
  input  logic [7:0]         dbus_in,
  input  logic               iom_,
  input  logic               rd_,
  input  logic               wr_,
  input  logic               inta_,
  output logic               intr,
  output logic [7:0]         dbus_out,
  output logic               dbus_oe
);

  logic [NUM_IRQ-1:0] imr, irr, isr, irq_q, elig, below, irr_next, isr_next;
  logic [1:0]  state;
  logic [2:0]  sel, sel_q, elig_idx, isr_idx;
  logic        elig_valid, isr_valid;
  logic        wr_q, inta_q, wr_hit;
  logic [1:0]  wr_off;
  logic [7:0]  wr_data, off;
  logic        hit, ack_fall, inta_rise, wr_rise, wr_commit;
  logic [15:0] vec;

  pic85_prio #(.N(NUM_IRQ)) u_elig (.vec(elig), .idx(elig_idx), .valid(elig_valid));
  pic85_prio #(.N(NUM_IRQ)) u_isr  (.vec(isr),  .idx(isr_idx),  .valid(isr_valid));

  always_comb begin
    off       = ioaddr - IO_BASE;
    hit       = iom_ && (off < 8'd3);
    ack_fall  = (state == ACK_IDLE) && inta_q && !inta_;
    inta_rise = !inta_q && inta_;
    wr_rise   = !wr_q && wr_;
    wr_commit = wr_rise && wr_hit;
    sel       = elig_valid ? elig_idx : 3'(NUM_IRQ - 1);
    vec       = VEC_BASE + 16'(sel_q) * 16'(VEC_STEP);
  end

  // An in-service level blocks itself and every lower priority.
  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++)
      below[i] = !isr_valid || (i < 32'(isr_idx));
    elig = irr & ~imr & below;
  end

  // EOI clears are applied before ACK sets and irq edges so the sets win.
  always_comb begin
    irr_next = irr;
    isr_next = isr;
    if (wr_commit && wr_off == PORT_CMD) begin
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (wr_data[CMD_SEOI]) begin
          if (i == 32'(wr_data[2:0])) isr_next[i] = 1'b0;
        end else if (wr_data[CMD_NSEOI] && isr_valid) begin
          if (i == 32'(isr_idx)) isr_next[i] = 1'b0;
        end
      end
    end
    if (ack_fall && elig_valid) begin
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        if (i == 32'(elig_idx)) begin
          isr_next[i] = 1'b1;
          irr_next[i] = 1'b0;
        end
      end
    end
    irr_next = irr_next | (irq & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imr     <= '1;
      irr     <= '0;
      isr     <= '0;
      irq_q   <= '0;
      wr_q    <= 1'b1;
      inta_q  <= 1'b1;
      wr_hit  <= 1'b0;
      wr_off  <= '0;
      wr_data <= '0;
      state   <= ACK_IDLE;
      sel_q   <= '0;
      intr    <= 1'b0;
    end else begin
      irq_q  <= irq;
      wr_q   <= wr_;
      inta_q <= inta_;
      irr    <= irr_next;
      isr    <= isr_next;
      if (iom_ && !wr_) begin
        wr_hit  <= hit;
        wr_off  <= off[1:0];
        wr_data <= dbus_in;
      end else if (wr_rise) begin
        wr_hit <= 1'b0;
      end
      if (wr_commit && wr_off == PORT_IMR) imr <= wr_data[NUM_IRQ-1:0];
      case (state)
        ACK_IDLE: if (ack_fall) begin
          state <= ACK1;
          sel_q <= sel;
        end
        ACK1:    if (inta_rise) state <= ACK2;
        ACK2:    if (inta_rise) state <= ACK3;
        ACK3:    if (inta_rise) state <= ACK_IDLE;
        default: state <= ACK_IDLE;
      endcase
      intr <= (state == ACK_IDLE) && !ack_fall && elig_valid;
    end
  end

  always_comb begin
    dbus_oe  = 1'b0;
    dbus_out = '0;
    if (state != ACK_IDLE && !inta_) begin
      dbus_oe = 1'b1;
      case (state)
        ACK1:    dbus_out = OP_CALL;
        ACK2:    dbus_out = vec[7:0];
        default: dbus_out = vec[15:8];
      endcase
    end else if (hit && !rd_) begin
      dbus_oe = 1'b1;
      case (off[1:0])
        PORT_CMD: dbus_out = 8'(isr);
        PORT_IMR: dbus_out = 8'(imr);
        default:  dbus_out = 8'(irr);
      endcase
    end
  end

endmodule

// File: tb/tb_pic85.sv
// Self-checking bench for pic85: directed scenarios plus random traffic
// compared against a register-level model of the controller.
module tb_pic85;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = '0;
  logic [7:0] ioaddr = '0;
  logic [7:0] dbus_in = '0;
  logic       iom_ = 1'b0;
  logic       rd_ = 1'b1;
  logic       wr_ = 1'b1;
  logic       inta_ = 1'b1;
  logic       intr;
  logic [7:0] dbus_out;
  logic       dbus_oe;

  always #5 clk = ~clk;

  pic85 #(.NUM_IRQ(8), .IO_BASE(8'h20), .VEC_BASE(16'h1000), .VEC_STEP(4)) dut (
    .clk(clk), .rst(rst), .irq(irq), .ioaddr(ioaddr), .dbus_in(dbus_in),
    .iom_(iom_), .rd_(rd_), .wr_(wr_), .inta_(inta_),
    .intr(intr), .dbus_out(dbus_out), .dbus_oe(dbus_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_imr, m_irr, m_isr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Eligible = pending & unmasked & strictly higher priority than the lowest in-service bit.
  function automatic logic [7:0] m_elig();
    logic [7:0] lowbit;
    lowbit = m_isr & (~m_isr + 8'd1);
    return m_irr & ~m_imr & ((m_isr == 8'h00) ? 8'hFF : (lowbit - 8'd1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_imr = 8'hFF;
    m_irr = 8'h00;
    m_isr = 8'h00;
  endtask

  task automatic io_write(input logic [7:0] offs, input logic [7:0] data);
    int k;
    ioaddr = 8'h20 + offs;
    dbus_in = data;
    iom_ = 1'b1;
    wr_ = 1'b0;
    tick();
    wr_ = 1'b1;
    tick();
    iom_ = 1'b0;
    dbus_in = $urandom;
    if (offs == 8'd1) m_imr = data;
    else if (offs == 8'd0) begin
      if (data[6]) m_isr[data[2:0]] = 1'b0;
      else if (data[5]) begin
        k = lowest(m_isr);
        if (k >= 0) m_isr[k] = 1'b0;
      end
    end
  endtask

  task automatic io_read(input logic [7:0] offs, output logic [7:0] d);
    ioaddr = 8'h20 + offs;
    iom_ = 1'b1;
    rd_ = 1'b0;
    #1;
    check("rd_oe", dbus_oe, 1);
    d = dbus_out;
    rd_ = 1'b1;
    iom_ = 1'b0;
    tick();
  endtask

  task automatic check_regs();
    logic [7:0] d;
    io_read(8'd0, d); check("isr", d, m_isr);
    io_read(8'd1, d); check("imr", d, m_imr);
    io_read(8'd2, d); check("irr", d, m_irr);
  endtask

  task automatic pulse(input logic [7:0] mask);
    irq = mask;
    tick();
    irq = '0;
    m_irr = m_irr | mask;
  endtask

  task automatic settle();
    tick();
    tick();
    check("intr", intr, m_elig() != 8'h00);
    check("idle_oe", dbus_oe, 0);
  endtask

  task automatic inta(input logic [15:0] want, input bit use_want);
    logic [7:0]  e;
    logic [15:0] v;
    int          sel;
    e = m_elig();
    sel = (e == 8'h00) ? 7 : lowest(e);
    v = use_want ? want : 16'(16'h1000 + sel * 4);
    if (e != 8'h00) begin
      m_isr[sel] = 1'b1;
      m_irr[sel] = 1'b0;
    end
    inta_ = 1'b0; tick();
    check("ack1_oe", dbus_oe, 1); check("ack1", dbus_out, 8'hCD); check("ack1_intr", intr, 0);
    inta_ = 1'b1; tick();
    check("ack_gap_oe", dbus_oe, 0);
    inta_ = 1'b0; tick();
    check("ack2", dbus_out, v[7:0]); check("ack2_intr", intr, 0);
    inta_ = 1'b1; tick();
    inta_ = 1'b0; tick();
    check("ack3", dbus_out, v[15:8]); check("ack3_intr", intr, 0);
    inta_ = 1'b1; tick();
    check("ack_end_oe", dbus_oe, 0);
  endtask

  initial begin
    logic [7:0] d;
    int op;

    // Reset state
    do_reset();
    check("rst_intr", intr, 0);
    check("rst_oe", dbus_oe, 0);
    check("rst_out", dbus_out, 0);
    check_regs();

    // Single request: 2-edge latency, CALL 100C
    io_write(8'd1, 8'h00);
    pulse(8'h08);
    check("lat_edge1", intr, 0);
    tick();
    check("lat_edge2", intr, 1);
    inta(16'h100C, 1);
    settle();
    check_regs();

    // Priority: irq2 beats irq5; irq5 waits for EOI
    do_reset();
    io_write(8'd1, 8'h00);
    pulse(8'h24);
    settle();
    inta(16'h1008, 1);
    settle();
    check_regs();
    io_write(8'd0, 8'h20);
    settle();
    inta(16'h1014, 1);
    settle();
    check_regs();

    // Masking: masked request still latches
    do_reset();
    pulse(8'h01);
    settle();
    io_read(8'd2, d);
    check("mask_irr", d, 8'h01);
    io_write(8'd1, 8'hFE);
    settle();

    // Nesting with specific EOI
    do_reset();
    io_write(8'd1, 8'h00);
    pulse(8'h10); settle();
    inta(16'h1010, 1);
    pulse(8'h40); settle();
    pulse(8'h02); settle();
    inta(16'h1004, 1);
    check_regs();
    io_write(8'd0, 8'h41);
    check_regs();
    io_write(8'd2, 8'hFF);
    io_write(8'd0, 8'h00);
    settle();
    check_regs();

    // Spurious acknowledge after masking the pending request
    do_reset();
    io_write(8'd1, 8'h00);
    pulse(8'h04); settle();
    io_write(8'd1, 8'hFF);
    inta(16'h101C, 1);
    settle();
    check_regs();

    // Reset asserted during ACK2 with inta_ low
    do_reset();
    io_write(8'd1, 8'h00);
    pulse(8'h01); settle();
    inta_ = 1'b0; tick();
    inta_ = 1'b1; tick();
    inta_ = 1'b0; tick();
    check("mid_oe_before", dbus_oe, 1);
    rst = 1'b1;
    tick();
    check("mid_oe", dbus_oe, 0);
    check("mid_intr", intr, 0);
    rst = 1'b0;
    inta_ = 1'b1;
    m_imr = 8'hFF; m_irr = 8'h00; m_isr = 8'h00;
    check_regs();

    // Random traffic against the model
    do_reset();
    io_write(8'd1, 8'h00);
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: pulse(8'($urandom));
        1: io_write(8'd1, 8'($urandom & $urandom & $urandom));
        2: io_write(8'd0, 8'h20);
        3: io_write(8'd0, 8'h40 | 8'($urandom_range(0, 7)));
        4: if (m_elig() != 8'h00 || $urandom_range(0, 3) == 0) inta(16'h0000, 0);
        5: check_regs();
        default: io_write(8'd2, 8'($urandom));
      endcase
      settle();
    end
    check_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
